// File: rtl/pipe_pkg.sv
// Shared definitions for the EXE->MEM stage: flag index map, default widths,
// and the per-edge action chosen from flush/stall.
package pipe_pkg;
   localparam int FLAG_Z     = 0;
   localparam int FLAG_N     = 1;
   localparam int FLAG_C     = 2;
   localparam int FLAG_V     = 3;
   localparam int DEF_DW     = 32;
   localparam int DEF_RW     = 5;
   localparam int DEF_NFLAG  = 4;

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_HOLD   = 2'd1,
      ACT_BUBBLE = 2'd2
   } act_e;

   // Flush wins over stall so a bubble can be inserted into a frozen stage.
   function automatic act_e pick_act(input logic flush, input logic stall);
      if (flush) return ACT_BUBBLE;
      if (stall) return ACT_HOLD;
      return ACT_LOAD;
   endfunction
endpackage

// File: rtl/flag_hold_reg.sv
// Architectural condition-flag register: each bit loads only when its own
// enable is set, otherwise it keeps its value.
module flag_hold_reg #(
   parameter int NFLAG = 4
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [NFLAG-1:0] en,
   input  logic [NFLAG-1:0] d,
   output logic [NFLAG-1:0] q
);
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q <= '0;
      end else begin
         for (int i = 0; i < NFLAG; i++) begin
            if (en[i]) q[i] <= d[i];
         end
      end
   end
endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid, stall/flush, persistent per-flag
// write-enabled condition flags, r0 write suppression and a bubble counter.
module exe_mem_pipe_reg
   import pipe_pkg::*;
#(
   parameter int DW            = DEF_DW,
   parameter int RW            = DEF_RW,
   parameter int NFLAG         = DEF_NFLAG,
   parameter int ZERO_REG_KILL = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             stall,
   input  logic             flush,
   input  logic             cnt_clr,
   input  logic             exe_valid,
   input  logic             exe_wreg,
   input  logic             exe_m2reg,
   input  logic             exe_wmem,
   input  logic [DW-1:0]    exe_alu,
   input  logic [DW-1:0]    exe_b,
   input  logic [RW-1:0]    exe_rn,
   input  logic [NFLAG-1:0] exe_flags,
   input  logic [NFLAG-1:0] exe_wflags,
   output logic             mem_valid,
   output logic             mem_wreg,
   output logic             mem_m2reg,
   output logic             mem_wmem,
   output logic [DW-1:0]    mem_alu,
   output logic [DW-1:0]    mem_b,
   output logic [RW-1:0]    mem_rn,
   output logic [NFLAG-1:0] mem_flags,
   output logic [CNT_W-1:0] bubble_cnt
);
   act_e             act;
   logic             load;
   logic             rn_kill;
   logic             bubble_in;
   logic [NFLAG-1:0] flag_en;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign act       = pick_act(flush, stall);
   assign load      = (act == ACT_LOAD);
   assign rn_kill   = (ZERO_REG_KILL != 0) && (exe_rn == '0);
   assign bubble_in = (act == ACT_BUBBLE) || (load && !exe_valid);
   // Only a real, loading instruction may touch the flags; bubbles keep them.
   assign flag_en   = {NFLAG{load & exe_valid}} & exe_wflags;

   flag_hold_reg #(.NFLAG(NFLAG)) u_flags (
      .clk  (clk),
      .clrn (clrn),
      .en   (flag_en),
      .d    (exe_flags),
      .q    (mem_flags)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         mem_valid <= 1'b0;
         mem_wreg  <= 1'b0;
         mem_m2reg <= 1'b0;
         mem_wmem  <= 1'b0;
         mem_alu   <= '0;
         mem_b     <= '0;
         mem_rn    <= '0;
      end else begin
         case (act)
            ACT_LOAD: begin
               mem_valid <= exe_valid;
               mem_wreg  <= exe_valid & exe_wreg & ~rn_kill;
               mem_m2reg <= exe_valid & exe_m2reg;
               mem_wmem  <= exe_valid & exe_wmem;
               mem_alu   <= exe_alu;
               mem_b     <= exe_b;
               mem_rn    <= exe_rn;
            end
            ACT_BUBBLE: begin
               // Datapath fields hold; they are don't-care behind a bubble.
               mem_valid <= 1'b0;
               mem_wreg  <= 1'b0;
               mem_m2reg <= 1'b0;
               mem_wmem  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)          bubble_cnt <= '0;
      else if (cnt_clr)   bubble_cnt <= '0;
      else if (bubble_in) bubble_cnt <= sat_inc(bubble_cnt);
   end
endmodule
